// File: rtl/mem_req_shim.sv
// Queuing/latency shim between the CPU memory ports and the external memory model.
// Handshake: a transfer happens on a rising edge where valid && ready; response channels have no ready.
module mem_req_shim_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int PTR_BITS = $clog2(DEPTH);

    logic [W-1:0]      mem [DEPTH];
    logic [PTR_BITS:0] wr_ptr;
    logic [PTR_BITS:0] rd_ptr;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_BITS] != rd_ptr[PTR_BITS]) &&
                      (wr_ptr[PTR_BITS-1:0] == rd_ptr[PTR_BITS-1:0]);
    assign pop_data = mem[rd_ptr[PTR_BITS-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[PTR_BITS-1:0]] <= push_data;
                wr_ptr <= wr_ptr + (PTR_BITS+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (PTR_BITS+1)'(1);
        end
    end
endmodule

module mem_req_shim #(
    parameter int TAG_BITS        = 5,
    parameter int ADDR_BITS       = 28,
    parameter int DATA_BITS       = 128,
    parameter int REQ_DEPTH       = 4,
    parameter int RESP_LATENCY    = 3,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cpu_req_valid,
    output logic                   cpu_req_ready,
    input  logic                   cpu_req_rw,
    input  logic [ADDR_BITS-1:0]   cpu_req_addr,
    input  logic [TAG_BITS-1:0]    cpu_req_tag,
    input  logic                   cpu_req_data_valid,
    output logic                   cpu_req_data_ready,
    input  logic [DATA_BITS-1:0]   cpu_req_data_bits,
    input  logic [DATA_BITS/8-1:0] cpu_req_data_mask,
    output logic                   cpu_resp_valid,
    output logic [TAG_BITS-1:0]    cpu_resp_tag,
    output logic [DATA_BITS-1:0]   cpu_resp_data,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_rw,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic [TAG_BITS-1:0]    mem_req_tag,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [TAG_BITS-1:0]    mem_resp_tag,
    input  logic [DATA_BITS-1:0]   mem_resp_data,
    output logic                   err_unexpected_resp
);
    localparam int MASK_BITS = DATA_BITS / 8;
    localparam int REQ_W     = 1 + ADDR_BITS + TAG_BITS;
    localparam int DAT_W     = DATA_BITS + MASK_BITS;
    localparam int CRED_BITS = $clog2(MAX_OUTSTANDING + 1);
    // One spare bit so unexpected responses cannot wrap the in-flight count.
    localparam int FLT_BITS  = CRED_BITS + 1;
    localparam logic [CRED_BITS-1:0] CRED_MAX = CRED_BITS'(MAX_OUTSTANDING);

    logic                 req_full, req_empty, data_full, data_empty;
    logic                 req_push, req_pop, data_push, data_pop;
    logic [REQ_W-1:0]     req_head;
    logic [DAT_W-1:0]     data_head;
    logic [CRED_BITS-1:0] credit;
    logic [FLT_BITS-1:0]  in_flight;
    logic                 rd_accept, rd_issue, unexpected;

    // Gated by reset_n so readies drop the instant reset asserts.
    assign cpu_req_ready      = reset_n && !req_full && (cpu_req_rw || credit != '0);
    assign cpu_req_data_ready = reset_n && !data_full;

    assign req_push  = cpu_req_valid && cpu_req_ready;
    assign req_pop   = mem_req_valid && mem_req_ready;
    assign data_push = cpu_req_data_valid && cpu_req_data_ready;
    assign data_pop  = mem_req_data_valid && mem_req_data_ready;

    mem_req_shim_fifo #(.W(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (req_push),
        .push_data ({cpu_req_rw, cpu_req_addr, cpu_req_tag}),
        .pop       (req_pop),
        .pop_data  (req_head),
        .full      (req_full),
        .empty     (req_empty)
    );

    mem_req_shim_fifo #(.W(DAT_W), .DEPTH(REQ_DEPTH)) u_data_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (data_push),
        .push_data ({cpu_req_data_bits, cpu_req_data_mask}),
        .pop       (data_pop),
        .pop_data  (data_head),
        .full      (data_full),
        .empty     (data_empty)
    );

    assign mem_req_valid                            = !req_empty;
    assign {mem_req_rw, mem_req_addr, mem_req_tag}  = req_head;
    assign mem_req_data_valid                       = !data_empty;
    assign {mem_req_data_bits, mem_req_data_mask}   = data_head;

    assign rd_accept  = req_push && !cpu_req_rw;
    assign rd_issue   = req_pop && !mem_req_rw;
    assign unexpected = mem_resp_valid && (in_flight == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credit <= CRED_MAX;
        end else if (rd_accept && !cpu_resp_valid) begin
            credit <= credit - CRED_BITS'(1);
        end else if (!rd_accept && cpu_resp_valid && credit != CRED_MAX) begin
            credit <= credit + CRED_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_flight           <= '0;
            err_unexpected_resp <= 1'b0;
        end else begin
            if (rd_issue && !(mem_resp_valid && !unexpected))
                in_flight <= in_flight + FLT_BITS'(1);
            else if (!rd_issue && mem_resp_valid && !unexpected)
                in_flight <= in_flight - FLT_BITS'(1);
            if (unexpected) err_unexpected_resp <= 1'b1;
        end
    end

    generate
        if (RESP_LATENCY == 0) begin : g_pass
            assign cpu_resp_valid = reset_n && mem_resp_valid;
            assign cpu_resp_tag   = reset_n ? mem_resp_tag : '0;
            assign cpu_resp_data  = reset_n ? mem_resp_data : '0;
        end else begin : g_delay
            logic [RESP_LATENCY-1:0] dl_valid;
            logic [TAG_BITS-1:0]     dl_tag  [RESP_LATENCY];
            logic [DATA_BITS-1:0]    dl_data [RESP_LATENCY];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    dl_valid <= '0;
                    for (int i = 0; i < RESP_LATENCY; i++) begin
                        dl_tag[i]  <= '0;
                        dl_data[i] <= '0;
                    end
                end else begin
                    dl_valid[0] <= mem_resp_valid;
                    dl_tag[0]   <= mem_resp_tag;
                    dl_data[0]  <= mem_resp_data;
                    for (int i = 1; i < RESP_LATENCY; i++) begin
                        dl_valid[i] <= dl_valid[i-1];
                        dl_tag[i]   <= dl_tag[i-1];
                        dl_data[i]  <= dl_data[i-1];
                    end
                end
            end

            assign cpu_resp_valid = dl_valid[RESP_LATENCY-1];
            assign cpu_resp_tag   = dl_tag[RESP_LATENCY-1];
            assign cpu_resp_data  = dl_data[RESP_LATENCY-1];
        end
    endgenerate
endmodule

// File: tb/tb_mem_req_shim.sv
// Scoreboard bench for mem_req_shim with default parameters (depth 4, latency 3, 8 credits).
module tb_mem_req_shim;
    localparam int TAG_BITS  = 5;
    localparam int ADDR_BITS = 28;
    localparam int DATA_BITS = 128;
    localparam int MASK_BITS = 16;
    localparam int LAT       = 3;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 cpu_req_valid = 1'b0, cpu_req_rw = 1'b0;
    logic                 cpu_req_ready, cpu_req_data_ready;
    logic [ADDR_BITS-1:0] cpu_req_addr = '0;
    logic [TAG_BITS-1:0]  cpu_req_tag = '0;
    logic                 cpu_req_data_valid = 1'b0;
    logic [DATA_BITS-1:0] cpu_req_data_bits = '0;
    logic [MASK_BITS-1:0] cpu_req_data_mask = '0;
    logic                 cpu_resp_valid;
    logic [TAG_BITS-1:0]  cpu_resp_tag;
    logic [DATA_BITS-1:0] cpu_resp_data;
    logic                 mem_req_valid, mem_req_rw;
    logic                 mem_req_ready = 1'b0;
    logic [ADDR_BITS-1:0] mem_req_addr;
    logic [TAG_BITS-1:0]  mem_req_tag;
    logic                 mem_req_data_valid;
    logic                 mem_req_data_ready = 1'b0;
    logic [DATA_BITS-1:0] mem_req_data_bits;
    logic [MASK_BITS-1:0] mem_req_data_mask;
    logic                 mem_resp_valid = 1'b0;
    logic [TAG_BITS-1:0]  mem_resp_tag = '0;
    logic [DATA_BITS-1:0] mem_resp_data = '0;
    logic                 err_unexpected_resp;

    mem_req_shim dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .cpu_req_valid       (cpu_req_valid),
        .cpu_req_ready       (cpu_req_ready),
        .cpu_req_rw          (cpu_req_rw),
        .cpu_req_addr        (cpu_req_addr),
        .cpu_req_tag         (cpu_req_tag),
        .cpu_req_data_valid  (cpu_req_data_valid),
        .cpu_req_data_ready  (cpu_req_data_ready),
        .cpu_req_data_bits   (cpu_req_data_bits),
        .cpu_req_data_mask   (cpu_req_data_mask),
        .cpu_resp_valid      (cpu_resp_valid),
        .cpu_resp_tag        (cpu_resp_tag),
        .cpu_resp_data       (cpu_resp_data),
        .mem_req_valid       (mem_req_valid),
        .mem_req_ready       (mem_req_ready),
        .mem_req_rw          (mem_req_rw),
        .mem_req_addr        (mem_req_addr),
        .mem_req_tag         (mem_req_tag),
        .mem_req_data_valid  (mem_req_data_valid),
        .mem_req_data_ready  (mem_req_data_ready),
        .mem_req_data_bits   (mem_req_data_bits),
        .mem_req_data_mask   (mem_req_data_mask),
        .mem_resp_valid      (mem_resp_valid),
        .mem_resp_tag        (mem_resp_tag),
        .mem_resp_data       (mem_resp_data),
        .err_unexpected_resp (err_unexpected_resp)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [33:0]  req_q[$];   // {rw, addr, tag}
    logic [143:0] dat_q[$];   // {data, mask}
    logic [164:0] resp_q[$];  // {cycle, tag, data}
    int n_checks = 0;
    int n_fail   = 0;
    int req_hs   = 0;
    int dat_hs   = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected_item(input string name, input logic [191:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    // Monitor: pops the expected queue whenever the DUT completes an output transfer.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_req_valid && mem_req_ready) begin
                req_hs++;
                if (req_q.size() == 0) unexpected_item("mem_req", {mem_req_rw, mem_req_addr, mem_req_tag});
                else check("mem_req", {mem_req_rw, mem_req_addr, mem_req_tag}, req_q.pop_front());
            end
            if (mem_req_data_valid && mem_req_data_ready) begin
                dat_hs++;
                if (dat_q.size() == 0) unexpected_item("mem_data", {mem_req_data_bits, mem_req_data_mask});
                else check("mem_data", {mem_req_data_bits, mem_req_data_mask}, dat_q.pop_front());
            end
            if (cpu_resp_valid) begin
                if (resp_q.size() == 0) unexpected_item("cpu_resp", {cpu_resp_tag, cpu_resp_data});
                else check("cpu_resp", {32'(cyc), cpu_resp_tag, cpu_resp_data}, resp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [DATA_BITS-1:0] resp_pattern(input logic [TAG_BITS-1:0] tag);
        return {4{24'hA5C300, 3'b000, tag}};
    endfunction

    // Drives n back-to-back reads; the first n_ok are expected to be accepted. Leaves valid high.
    task automatic read_burst(input int n, input int n_ok, input int base_tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cpu_req_valid = 1'b1;
            cpu_req_rw    = 1'b0;
            cpu_req_tag   = TAG_BITS'(base_tag + i);
            cpu_req_addr  = ADDR_BITS'(32'h100 + base_tag + i);
            @(negedge clk);
            check("rd_ready", cpu_req_ready, (i < n_ok));
            if (i == 0) check("no_bypass", mem_req_valid, 1'b0);
            if (i == 1) check("first_mem_valid", mem_req_valid, 1'b1);
            if (i < n_ok) req_q.push_back({1'b0, ADDR_BITS'(32'h100 + base_tag + i), TAG_BITS'(base_tag + i)});
        end
    endtask

    task automatic mem_resp(input int tag);
        @(posedge clk); #1;
        mem_resp_valid = 1'b1;
        mem_resp_tag   = TAG_BITS'(tag);
        mem_resp_data  = resp_pattern(TAG_BITS'(tag));
        resp_q.push_back({32'(cyc + LAT), TAG_BITS'(tag), resp_pattern(TAG_BITS'(tag))});
    endtask

    task automatic resp_burst(input int n, input int base_tag);
        for (int i = 0; i < n; i++) mem_resp(base_tag + i);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((req_q.size() + dat_q.size() + resp_q.size()) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", req_q.size() + dat_q.size() + resp_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", cpu_req_ready, 1'b0);
        check("rst_data_ready", cpu_req_data_ready, 1'b0);
        check("rst_mem_valid", mem_req_valid, 1'b0);
        check("rst_mem_data_valid", mem_req_data_valid, 1'b0);
        check("rst_resp_valid", cpu_resp_valid, 1'b0);
        check("rst_err", err_unexpected_resp, 1'b0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", cpu_req_ready, 1'b1);

        // Fill the request FIFO with memory stalled; fifth read must be refused.
        read_burst(5, 4, 1);
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        wait_drain(20);

        // Back-to-back responses tags 1..4, each three cycles later.
        resp_burst(4, 1);
        wait_drain(20);

        // Write with its data beat two cycles after the request.
        mem_req_data_ready = 1'b1;
        @(posedge clk); #1;
        cpu_req_valid = 1'b1; cpu_req_rw = 1'b1;
        cpu_req_addr  = 28'h10; cpu_req_tag = 5'd3;
        @(negedge clk);
        check("wr_req_ready", cpu_req_ready, 1'b1);
        req_q.push_back({1'b1, 28'h10, 5'd3});
        @(posedge clk); #1;
        cpu_req_valid = 1'b0; cpu_req_rw = 1'b0;
        @(posedge clk); #1;
        cpu_req_data_valid = 1'b1;
        cpu_req_data_bits  = 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF;
        cpu_req_data_mask  = 16'hFFFF;
        @(negedge clk);
        check("wr_data_ready", cpu_req_data_ready, 1'b1);
        dat_q.push_back({128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF, 16'hFFFF});
        @(posedge clk); #1;
        cpu_req_data_valid = 1'b0;
        wait_drain(20);

        // Credit cap: eight reads in flight, ninth held until a response returns.
        read_burst(9, 8, 8);
        mem_resp(8);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("cap_hold", cpu_req_ready, 1'b0);
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
        end
        @(negedge clk);
        check("cap_release", cpu_req_ready, 1'b1);
        req_q.push_back({1'b0, ADDR_BITS'(32'h100 + 16), TAG_BITS'(16)});
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        resp_burst(8, 9);
        wait_drain(40);

        // Response with nothing in flight: sticky error, response still forwarded.
        @(negedge clk);
        check("err_clear", err_unexpected_resp, 1'b0);
        mem_resp(7);
        @(negedge clk);
        check("err_same_cycle", err_unexpected_resp, 1'b0);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("err_sticky", err_unexpected_resp, 1'b1);
            @(posedge clk);
        end
        wait_drain(20);

        // Reset mid-burst drops queued requests, beats and delayed responses.
        mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
        @(posedge clk); #1;
        cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_tag = 5'd20; cpu_req_addr = 28'h400;
        cpu_req_data_valid = 1'b1; cpu_req_data_bits = '1; cpu_req_data_mask = 16'h00FF;
        mem_resp_valid = 1'b1; mem_resp_tag = 5'd9; mem_resp_data = resp_pattern(5'd9);
        resp_q.push_back({32'(cyc + LAT), 5'd9, resp_pattern(5'd9)});
        @(posedge clk); #1;
        cpu_req_tag = 5'd21; cpu_req_data_valid = 1'b0; mem_resp_valid = 1'b0;
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mrst_req_ready", cpu_req_ready, 1'b0);
        check("mrst_mem_valid", mem_req_valid, 1'b0);
        check("mrst_mem_data_valid", mem_req_data_valid, 1'b0);
        check("mrst_resp_valid", cpu_resp_valid, 1'b0);
        check("mrst_err", err_unexpected_resp, 1'b0);
        req_q.delete(); dat_q.delete(); resp_q.delete();
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_mem_valid", mem_req_valid, 1'b0);
        check("post_rst_data_valid", mem_req_data_valid, 1'b0);
        check("post_rst_err", err_unexpected_resp, 1'b0);
        // A full set of eight credits must be available again.
        mem_req_ready = 1'b1;
        read_burst(9, 8, 24);
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        resp_burst(8, 24);
        wait_drain(40);

        // Push and pop together at 3/4 occupancy across pointer wrap (writes: no credit use).
        mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
        for (int i = 0; i < 23; i++) begin
            @(posedge clk); #1;
            if (i >= 3) begin
                mem_req_ready = 1'b1; mem_req_data_ready = 1'b1;
            end
            cpu_req_valid = 1'b1; cpu_req_rw = 1'b1;
            cpu_req_addr  = ADDR_BITS'(32'h300 + i);
            cpu_req_tag   = TAG_BITS'(i);
            cpu_req_data_valid = 1'b1;
            cpu_req_data_bits  = {4{32'hBEEF0000 + 32'(i)}};
            cpu_req_data_mask  = MASK_BITS'(i);
            @(negedge clk);
            check("pp_req_ready", cpu_req_ready, 1'b1);
            check("pp_data_ready", cpu_req_data_ready, 1'b1);
            req_q.push_back({1'b1, ADDR_BITS'(32'h300 + i), TAG_BITS'(i)});
            dat_q.push_back({{4{32'hBEEF0000 + 32'(i)}}, MASK_BITS'(i)});
        end
        @(posedge clk); #1;
        cpu_req_valid = 1'b0; cpu_req_rw = 1'b0; cpu_req_data_valid = 1'b0;
        req_hs = 0; dat_hs = 0;
        repeat (6) @(posedge clk);
        #1;
        check("pp_req_occupancy", req_hs, 3);
        check("pp_data_occupancy", dat_hs, 3);
        wait_drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
